cache_access_arbiter: RTL
=========================

# cache_access_arbiter

Round-robin controller that shares the single access port of the `cacheSim` cache model between `NUM_REQ` requesters (for example instruction-fetch and data trace streams). Operation per access:
- Accepts one request at a time through a valid/ready handshake.
- Drives the latched read/write flag and address into the cache for exactly one cycle.
- Waits for the cache's completion pulse, then returns the hit/miss result to the winning requester.

A watchdog bounds every wait, so a stalled cache cannot hang the trace bench.

## Interface
- `NUM_REQ`, 2, number of requesters; legal range 2..8.
- `ADDRESS_SIZE`, 16, address width in bits; matches the cache's `ADDRESS_SIZE`.
- `TIMEOUT`, 64, maximum cycles spent in WAIT before an access is abandoned; at least 2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request pending.
- `req_rw`  in  NUM_REQ  per-requester access type; 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDRESS_SIZE  per-requester address; requester i occupies bits [i*ADDRESS_SIZE +: ADDRESS_SIZE].
- `req_ready`  out  NUM_REQ  one-hot grant; handshake completes on the edge where `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  NUM_REQ  one-hot, single-cycle completion pulse.
- `resp_hit`  out  1  result qualifying `resp_valid`; 1 = hit.
- `cache_valid`  out  1  one-cycle access strobe to the cache.
- `cache_rw`  out  1  latched access type.
- `cache_address`  out  ADDRESS_SIZE  latched address.
- `cache_done`  in  1  cache completion pulse.
- `cache_hit`  in  1  hit flag, valid with `cache_done`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `timeout_err`  out  1  sticky flag: set by any watchdog expiry, cleared only by `reset`.
- `grant_count`  out  32  number of accepted requests; saturates at 32'hFFFF_FFFF.

## Operation
- Reset values:
  - FSM is in IDLE; round-robin pointer `ptr` = 0.
  - All outputs are 0, including `cache_address`, `grant_count` and `timeout_err`.
  - Reset takes effect immediately on assertion, including mid-access. The in-flight access is dropped and no `resp_valid` is issued for it.
- IDLE state:
  - The winner is the first `i` with `req_valid[i]` high, searching `ptr`, `ptr+1`, … and wrapping modulo `NUM_REQ`.
  - `req_ready[winner]` is driven combinationally high; all other `req_ready` bits are 0. With no request pending, `req_ready` is 0.
  - On the accepting edge:
    - `req_rw[winner]` and `req_addr[winner]` are latched into `cache_rw` and `cache_address`.
    - The winner index is stored.
    - `grant_count` increments.
    - The FSM moves to ISSUE.
- ISSUE state:
  - `cache_valid` = 1 for exactly this one cycle.
  - `req_ready` = 0.
  - The watchdog counter is cleared.
  - The FSM moves to WAIT on the next edge.
- WAIT state:
  - The watchdog counter increments every cycle.
  - If `cache_done` is sampled high on an edge:
    - `resp_valid[winner]` and `resp_hit` (= `cache_hit`) are registered high for the following cycle.
    - `ptr` becomes `(winner+1) mod NUM_REQ`.
    - The FSM returns to IDLE.
  - If the watchdog reaches `TIMEOUT` with no `cache_done`:
    - `resp_valid[winner]` is pulsed with `resp_hit` = 0.
    - `timeout_err` is set.
    - `ptr` advances exactly as on a normal completion.
    - The FSM returns to IDLE.
  - If `cache_done` arrives on the same edge as expiry, the completion wins and `timeout_err` is not set.
- `cache_done` sampled in IDLE or ISSUE is ignored.
- `cache_rw` and `cache_address` hold their last latched value outside ISSUE.
- `resp_hit` is 0 in every cycle where `resp_valid` is 0.
- A requester may drop `req_valid` before it is granted, with no side effect. The arbiter does not rely on requests being held.

## Timing
- Request accepted at edge T:
  - `cache_valid` is high during cycle T..T+1.
  - WAIT begins at T+1.
- Earliest `cache_done` is the edge T+2; in that case `resp_valid` is high in cycle T+2..T+3.
- Back-to-back throughput:
  - IDLE is re-entered in the same cycle `resp_valid` is high, so the next grant can complete at edge T+3.
  - Minimum 3 cycles per access.
- Timeout: `resp_valid` is high `TIMEOUT` cycles after WAIT entry.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, …, NUM_REQ-1, 0. No requester waits more than `NUM_REQ-1` accesses.

## Test plan
- Reset then single request: `req_valid`=2'b01, `req_rw[0]`=0, addr 16'h1A30; cache returns `cache_done`+`cache_hit`=1 two cycles later.
  - Expect `req_ready`=01 at T.
  - Expect `cache_valid` for one cycle with address 1A30.
  - Expect `resp_valid`=01 with `resp_hit`=1.
  - Expect `grant_count`=1.
- Both requesters continuously valid for 6 accesses, cache responding with minimum latency:
  - Grant order 0,1,0,1,0,1.
  - Each access takes 3 cycles; `grant_count`=6.
- Requester 1 is granted and `cache_done` is never asserted; `TIMEOUT`=64:
  - `resp_valid`=10 with `resp_hit`=0, 64 cycles after WAIT entry.
  - `timeout_err`=1 and stays high; the next request is serviced normally.
- `cache_done` pulsed in IDLE and in ISSUE: no `resp_valid` is generated. A later `cache_done` in WAIT completes normally.
- `reset` asserted while in WAIT:
  - All outputs go to 0 asynchronously; no response pulse is issued.
  - After deassertion, a request from requester 1 is granted first (`ptr`=0 with only requester 1 valid).
- `cache_done` coincident with watchdog expiry: response carries `cache_hit`, and `timeout_err` stays 0.

Source files
------------

// File: rtl/cache_access_arbiter.sv
// Round-robin arbiter sharing the single cacheSim access port between NUM_REQ requesters.
// Each grant issues one cache strobe, then waits (with a watchdog) for the completion pulse.
module cache_access_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESS_SIZE = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_rw,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic                            resp_hit,
  output logic                            cache_valid,
  output logic                            cache_rw,
  output logic [ADDRESS_SIZE-1:0]         cache_address,
  input  logic                            cache_done,
  input  logic                            cache_hit,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [31:0]                     grant_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0]   NREQ    = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST    = IW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           win_q, win_d;
  logic                    rw_q, rw_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [31:0]             gc_q, gc_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic                    terr_q, terr_d;
  logic [NUM_REQ-1:0]      rv_q, rv_d;
  logic                    rh_q, rh_d;

  logic                    found;
  logic [IW-1:0]           pick;
  logic [IW:0]             cand;
  logic [IW-1:0]           ptrNext;

  // Search starts at ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign ptrNext = (win_q == LAST) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    gc_d      = gc_q;
    wd_d      = wd_q;
    terr_d    = terr_q;
    rv_d      = '0;
    rh_d      = 1'b0;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          win_d   = pick;
          rw_d    = req_rw[pick];
          addr_d  = req_addr[pick*ADDRESS_SIZE +: ADDRESS_SIZE];
          if (gc_q != 32'hFFFF_FFFF) gc_d = gc_q + 32'd1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WW'(1);
        // A completion on the expiry edge takes precedence over the timeout.
        if (cache_done) begin
          rv_d[win_q] = 1'b1;
          rh_d        = cache_hit;
          ptr_d       = ptrNext;
          state_d     = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          rv_d[win_q] = 1'b1;
          terr_d      = 1'b1;
          ptr_d       = ptrNext;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      gc_q    <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
      rv_q    <= '0;
      rh_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      gc_q    <= gc_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
      rv_q    <= rv_d;
      rh_q    <= rh_d;
    end
  end

  assign cache_valid   = (state_q == S_ISSUE);
  assign busy          = (state_q != S_IDLE);
  assign cache_rw      = rw_q;
  assign cache_address = addr_q;
  assign grant_count   = gc_q;
  assign timeout_err   = terr_q;
  assign resp_valid    = rv_q;
  assign resp_hit      = rh_q;

endmodule
